// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt dispatch path.
package irq_pkg;

    localparam int IRQ_CODE_W = 3;
    localparam int PC_W       = 15;

    localparam logic [PC_W-1:0] VEC_BASE_DEFAULT  = 15'h0010;
    localparam int              VEC_SHIFT_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ISR,
        ACK
    } irq_state_t;

endpackage

// File: rtl/irq_dispatch_if.sv
// Bus between the core/queue-controller side (master) and irq_dispatch (slave).
// The mask write port exists only when IRQ_MASK_EN is defined.
interface irq_dispatch_if;
    import irq_pkg::*;

    logic [IRQ_CODE_W-1:0] irq_code;
    logic [PC_W-1:0]       pc;
    logic                  instr_done;
    logic                  int_en;
    logic                  reti;
    logic                  take;
    logic [PC_W-1:0]       vec_addr;
    logic [PC_W-1:0]       ret_addr;
    logic                  eirq;
    logic                  in_isr;
    logic [IRQ_CODE_W-1:0] active_code;
    logic                  ovr;
`ifdef IRQ_MASK_EN
    logic                  mask_wr;
    logic [7:0]            mask_din;

    modport master (
        output irq_code, pc, instr_done, int_en, reti, mask_wr, mask_din,
        input  take, vec_addr, ret_addr, eirq, in_isr, active_code, ovr
    );

    modport slave (
        input  irq_code, pc, instr_done, int_en, reti, mask_wr, mask_din,
        output take, vec_addr, ret_addr, eirq, in_isr, active_code, ovr
    );
`else
    modport master (
        output irq_code, pc, instr_done, int_en, reti,
        input  take, vec_addr, ret_addr, eirq, in_isr, active_code, ovr
    );

    modport slave (
        input  irq_code, pc, instr_done, int_en, reti,
        output take, vec_addr, ret_addr, eirq, in_isr, active_code, ovr
    );
`endif

endinterface

// File: rtl/irq_vec_calc.sv
// Maps an interrupt code to its vector slot address; the add wraps at 2^PC_W.
module irq_vec_calc
    import irq_pkg::*;
#(
    parameter logic [PC_W-1:0] VEC_BASE  = VEC_BASE_DEFAULT,
    parameter int              VEC_SHIFT = VEC_SHIFT_DEFAULT
) (
    input  logic [IRQ_CODE_W-1:0] code,
    output logic [PC_W-1:0]       vec_addr
);

    logic [PC_W-1:0] offset;

    always_comb begin
        offset   = {{(PC_W-IRQ_CODE_W){1'b0}}, code} << VEC_SHIFT;
        vec_addr = VEC_BASE + offset;
    end

endmodule

// File: rtl/irq_dispatch.sv
// Core-side interrupt responder: latches a queued code, redirects the core at an
// enabled instruction boundary, and pulses eirq on return. Optional: IRQ_MASK_EN.
module irq_dispatch
    import irq_pkg::*;
#(
    parameter logic [PC_W-1:0] VEC_BASE  = VEC_BASE_DEFAULT,
    parameter int              VEC_SHIFT = VEC_SHIFT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    irq_dispatch_if.slave bus
);

    irq_state_t            state;
    logic [IRQ_CODE_W-1:0] active_code;
    logic [PC_W-1:0]       ret_addr;
    logic                  ovr;
    logic [PC_W-1:0]       vec_addr;
    logic                  code_valid;
    logic                  code_ok;
    logic                  take;

    assign code_valid = (bus.irq_code != '0);

`ifdef IRQ_MASK_EN
    logic [7:0] mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= 8'hFE;
        end else if (bus.mask_wr) begin
            mask <= bus.mask_din;
        end
    end

    assign code_ok = code_valid && mask[bus.irq_code];
`else
    assign code_ok = code_valid;
`endif

    assign take = (state == PEND) && bus.instr_done && bus.int_en;

    // A code arriving in ACK is the queue controller answering eirq, so it is a
    // fresh request rather than an overrun. Masked codes still go through ACK so
    // the queue advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            active_code <= '0;
            ret_addr    <= '0;
            ovr         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (code_ok) begin
                        active_code <= bus.irq_code;
                        state       <= PEND;
                    end else if (code_valid) begin
                        state <= ACK;
                    end
                end
                PEND: begin
                    if (code_valid) ovr <= 1'b1;
                    if (take) begin
                        ret_addr <= bus.pc;
                        state    <= ISR;
                    end
                end
                ISR: begin
                    if (code_valid) ovr <= 1'b1;
                    if (bus.reti) state <= ACK;
                end
                ACK: begin
                    if (code_ok) begin
                        active_code <= bus.irq_code;
                        state       <= PEND;
                    end else if (code_valid) begin
                        active_code <= '0;
                        state       <= ACK;
                    end else begin
                        active_code <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    irq_vec_calc #(
        .VEC_BASE  (VEC_BASE),
        .VEC_SHIFT (VEC_SHIFT)
    ) u_vec_calc (
        .code     (active_code),
        .vec_addr (vec_addr)
    );

    assign bus.take        = take;
    assign bus.eirq        = (state == ACK);
    assign bus.in_isr      = (state == ISR);
    assign bus.active_code = active_code;
    assign bus.ret_addr    = ret_addr;
    assign bus.ovr         = ovr;
    assign bus.vec_addr    = vec_addr;

endmodule
